// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: op codes, FSM states,
// data width and a conditional two's-complement helper.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = 5;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_ITER = 2'd2,
    ST_DIV_FIX  = 2'd3
  } md_state_e;

  // Unsigned negate keeps 0x80000000 as its own magnitude, so no overflow case.
  function automatic logic [MD_WIDTH-1:0] md_cneg(input logic [MD_WIDTH-1:0] v,
                                                   input logic              neg);
    return neg ? (-v) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, done pulses
// in the cycle after the last step, quotient/remainder held until the next start.
module div_core
  import md_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [MD_WIDTH-1:0] dividend_i,
  input  logic [MD_WIDTH-1:0] divisor_i,
  output logic                done_o,
  output logic [MD_WIDTH-1:0] quotient_o,
  output logic [MD_WIDTH-1:0] remainder_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_WIDTH - 1);

  logic [MD_WIDTH-1:0] rem_q, rem_d;
  logic [MD_WIDTH-1:0] quo_q, quo_d;
  logic [MD_WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic [MD_WIDTH:0]   rem_sh;
  logic [MD_WIDTH:0]   diff;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    rem_sh = {rem_q, quo_q[MD_WIDTH-1]};
    // rem < divisor always holds, so bit MD_WIDTH of diff is a clean borrow flag
    diff   = rem_sh - {1'b0, dvs_q};
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = diff[MD_WIDTH] ? rem_sh[MD_WIDTH-1:0] : diff[MD_WIDTH-1:0];
      quo_d = {quo_q[MD_WIDTH-2:0], ~diff[MD_WIDTH]};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO register pair with multi-cycle multiply and iterative divide sequencing.
// Define HILO_BYPASS_EN to forward the final-cycle result and drop busy one cycle early.
//
// state       | meaning
// ST_IDLE     | no op in flight; MTHI/MTLO/MULT/DIV accepted here
// ST_MUL_WAIT | product captured, counting down to the HI/LO write
// ST_DIV_ITER | div_core producing one quotient bit per cycle
// ST_DIV_FIX  | signs applied to quotient/remainder, HI/LO written
module hilo_md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_ITERS    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                md_start,
  input  logic [2:0]          md_op,
  input  logic [MD_WIDTH-1:0] rs_value,
  input  logic [MD_WIDTH-1:0] rt_value,
  input  logic                is_mf_hi,
  input  logic                is_mf_lo,
  output logic [MD_WIDTH-1:0] reg_hi,
  output logic [MD_WIDTH-1:0] reg_lo,
  output logic                md_busy,
  output logic                md_stall
);

  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_LAST = CNT_W'(DIV_ITERS - 1);

  md_state_e             state_q, state_d;
  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MD_WIDTH-1:0]   hi_q, hi_d;
  logic [MD_WIDTH-1:0]   lo_q, lo_d;
  logic [2*MD_WIDTH-1:0] prod_q, prod_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;

  logic                  div_start;
  logic                  div_done;
  logic [MD_WIDTH-1:0]   div_quo;
  logic [MD_WIDTH-1:0]   div_rem;
  logic [MD_WIDTH-1:0]   dividend_mag;
  logic [MD_WIDTH-1:0]   divisor_mag;
  logic                  sgn_a;
  logic                  sgn_b;
  logic [2*MD_WIDTH-1:0] mul_a;
  logic [2*MD_WIDTH-1:0] mul_b;
  logic [2*MD_WIDTH-1:0] mul_full;
  logic [MD_WIDTH-1:0]   res_hi;
  logic [MD_WIDTH-1:0]   res_lo;
  logic                  final_cycle;
  logic                  busy_int;
  logic                  accept;

  // Sign-extended 64-bit operands give the exact signed or unsigned product mod 2^64
  always_comb begin
    sgn_a        = (md_op == MD_OP_MULT || md_op == MD_OP_DIV) & rs_value[MD_WIDTH-1];
    sgn_b        = (md_op == MD_OP_MULT || md_op == MD_OP_DIV) & rt_value[MD_WIDTH-1];
    mul_a        = {{MD_WIDTH{sgn_a}}, rs_value};
    mul_b        = {{MD_WIDTH{sgn_b}}, rt_value};
    mul_full     = mul_a * mul_b;
    dividend_mag = md_cneg(rs_value, sgn_a);
    divisor_mag  = md_cneg(rt_value, sgn_b);
  end

  always_comb begin
    res_hi = prod_q[2*MD_WIDTH-1:MD_WIDTH];
    res_lo = prod_q[MD_WIDTH-1:0];
    if (state_q == ST_DIV_FIX) begin
      res_hi = md_cneg(div_rem, rneg_q);
      res_lo = md_cneg(div_quo, qneg_q);
    end
    final_cycle = ((state_q == ST_MUL_WAIT) && (cnt_q == '0)) ||
                  ((state_q == ST_DIV_FIX) && div_done);
  end

`ifdef HILO_BYPASS_EN
  assign busy_int = busy_q & ~final_cycle;
  assign reg_hi   = final_cycle ? res_hi : hi_q;
  assign reg_lo   = final_cycle ? res_lo : lo_q;
`else
  assign busy_int = busy_q;
  assign reg_hi   = hi_q;
  assign reg_lo   = lo_q;
`endif

  // In bypass builds the final cycle is already non-busy, so a new op lands on top of the write
  assign accept   = md_start & ~busy_int & ((state_q == ST_IDLE) | final_cycle);
  assign md_busy  = busy_int;
  assign md_stall = busy_int & (md_start | is_mf_hi | is_mf_lo);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_start = 1'b0;

    case (state_q)
      ST_MUL_WAIT: begin
        if (cnt_q == '0) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_ITER: begin
        if (cnt_q == DIV_CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DIV_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV_FIX: begin
        if (div_done) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      case (md_op)
        MD_OP_MTHI: hi_d = rs_value;
        MD_OP_MTLO: lo_d = rs_value;
        MD_OP_MULT, MD_OP_MULTU: begin
          prod_d  = mul_full;
          cnt_d   = MUL_CNT_INIT;
          state_d = ST_MUL_WAIT;
        end
        MD_OP_DIV, MD_OP_DIVU: begin
          qneg_d    = sgn_a ^ sgn_b;
          rneg_d    = sgn_a;
          div_start = 1'b1;
          cnt_d     = '0;
          state_d   = ST_DIV_ITER;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  div_core u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (dividend_mag),
    .divisor_i   (divisor_mag),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl: scoreboard of expected HI/LO/latency per op,
// checked when md_busy drops. Honours HILO_BYPASS_EN for latency expectations.
module tb_hilo_md_ctrl;
  import md_pkg::*;

`ifdef HILO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int MLAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_value = '0;
  logic [31:0] rt_value = '0;
  logic        is_mf_hi = 1'b0;
  logic        is_mf_lo = 1'b0;
  logic [31:0] reg_hi;
  logic [31:0] reg_lo;
  logic        md_busy;
  logic        md_stall;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  hilo_md_ctrl #(.MULT_LATENCY(MLAT), .DIV_ITERS(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_value (rs_value),
    .rt_value (rt_value),
    .is_mf_hi (is_mf_hi),
    .is_mf_lo (is_mf_lo),
    .reg_hi   (reg_hi),
    .reg_lo   (reg_lo),
    .md_busy  (md_busy),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      MD_OP_MULT:  begin q = sa * sb; res = q; end
      MD_OP_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_OP_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_OP_DIV: begin
        if (b == 0) res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (op == MD_OP_MULT || op == MD_OP_MULTU) ? (MLAT - BYP) : (33 - BYP);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    exp_t        e;
    logic [63:0] m;
    m     = model(op, a, b);
    e.tag = tag;
    e.hi  = m[63:32];
    e.lo  = m[31:0];
    e.lat = exp_lat(op);
    sb_q.push_back(e);
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    rs_value = a;
    rt_value = b;
    tick();
    md_start = 1'b0;
  endtask

  task automatic pop_check(input int cyc);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, "_bound"}, 64'(cyc < 100), 64'd1);
    chk({e.tag, "_lat"},   64'(cyc), 64'(e.lat));
    chk({e.tag, "_hi"},    {32'd0, reg_hi}, {32'd0, e.hi});
    chk({e.tag, "_lo"},    {32'd0, reg_lo}, {32'd0, e.lo});
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int cyc;
    push_exp(tag, op, a, b);
    drive_op(op, a, b);
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    pop_check(cyc);
  endtask

  initial begin
    int          cyc;
    int          lo_bad;
    logic [31:0] lo_prev;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_hi",   {32'd0, reg_hi}, 64'd0);
    chk("reset_lo",   {32'd0, reg_lo}, 64'd0);
    chk("reset_busy", 64'(md_busy), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    drive_op(MD_OP_MTHI, 32'hA5A5_A5A5, 32'h0);
    chk("mthi_hi",   {32'd0, reg_hi}, 64'hA5A5_A5A5);
    chk("mthi_lo",   {32'd0, reg_lo}, 64'd0);
    chk("mthi_busy", 64'(md_busy), 64'd0);
    drive_op(MD_OP_MTLO, 32'h5A5A_1234, 32'h0);
    chk("mtlo_lo", {32'd0, reg_lo}, 64'h5A5A_1234);
    chk("mtlo_hi", {32'd0, reg_hi}, 64'hA5A5_A5A5);

    drive_op(3'd6, 32'hDEAD_BEEF, 32'h1);
    chk("noop_hi",   {32'd0, reg_hi}, 64'hA5A5_A5A5);
    chk("noop_lo",   {32'd0, reg_lo}, 64'h5A5A_1234);
    chk("noop_busy", 64'(md_busy), 64'd0);
    is_mf_lo = 1'b1;
    #1 chk("idle_stall", 64'(md_stall), 64'd0);
    is_mf_lo = 1'b0;

    run_op("mult_neg",   MD_OP_MULT,  32'hFFFF_FFFD, 32'd7);
    run_op("multu_max2", MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op("multu_sq",   MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg",    MD_OP_DIV,   32'hFFFF_FFF9, 32'd2);

    lo_prev = reg_lo;
    push_exp("stall_divu", MD_OP_DIVU, 32'd100, 32'd7);
    drive_op(MD_OP_DIVU, 32'd100, 32'd7);
    md_start = 1'b1;
    md_op    = MD_OP_MTLO;
    rs_value = 32'h0000_1234;
    is_mf_lo = 1'b1;
    cyc      = 0;
    lo_bad   = 0;
    while (md_stall === 1'b1 && cyc < 100) begin
      if (reg_lo !== lo_prev) lo_bad++;
      tick();
      cyc++;
    end
    chk("stall_lo_held", 64'(lo_bad), 64'd0);
    pop_check(cyc);
    tick();
    md_start = 1'b0;
    is_mf_lo = 1'b0;
    chk("held_start_lo",   {32'd0, reg_lo}, 64'h0000_1234);
    chk("held_start_hi",   {32'd0, reg_hi}, 64'd2);
    chk("held_start_busy", 64'(md_busy), 64'd0);

    run_op("divu_zero",  MD_OP_DIVU, 32'd9, 32'd0);
    run_op("div_ovf",    MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_negz",   MD_OP_DIV,  32'hFFFF_FFF7, 32'd0);
    run_op("div_minpos", MD_OP_DIV,  32'h8000_0000, 32'd3);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i[0]) rb = rb >> 20;
      if (rb == 0) rb = 32'd1;
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    drive_op(MD_OP_MTHI, 32'h1111_1111, 32'h0);
    drive_op(MD_OP_MTLO, 32'h2222_2222, 32'h0);
    drive_op(MD_OP_DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    chk("pre_reset_busy", 64'(md_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi",   {32'd0, reg_hi}, 64'd0);
    chk("midrst_lo",   {32'd0, reg_lo}, 64'd0);
    chk("midrst_busy", 64'(md_busy), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    run_op("after_rst", MD_OP_MULTU, 32'd3, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
